sub_arbiter: RTL and testbench

Two-requester round-robin arbiter that time-shares the single 64-bit `subtractor` datapath between the ALU SUB/SUBU path (requester 0) and the branch-compare unit (requester 1). It registers the winning requester's operands onto the subtractor inputs and captures the result one cycle later. It returns the result on a shared bus through a per-requester valid/ready response handshake. It sits between the decode/issue logic and the `subtractor` instance.

---
 rtl/sub_arbiter.sv | 126 ++++++++++++
 tb/tb_sub_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin share of one subtractor
// between ALU SUB/SUBU (req 0) and branch compare (req 1).
module sub_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             bin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             bin1,
  output logic [1:0]       gnt,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic [WIDTH-1:0] a_sub,
  output logic [WIDTH-1:0] b_sub,
  output logic             s_c_in,
  input  logic [WIDTH-1:0] difference,
  input  logic             s_c_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_q;
  logic             owner_q;
  logic [1:0]       gnt_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  logic             win_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic             cin_d;
  logic             hs;

  // Round-robin pick: lone requester wins, tie goes to !last
  always_comb begin
    win_d = ~last_q;
    if (req == 2'b01) win_d = 1'b0;
    if (req == 2'b10) win_d = 1'b1;
    a_d   = win_d ? a1 : a0;
    b_d   = win_d ? b1 : b0;
    cin_d = win_d ? bin1 : bin0;
  end

  assign hs = rsp_ready[owner_q];

  // Arbiter FSM with registered operands, grant and response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            owner_q <= win_d;
            last_q  <= win_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          diff_q      <= difference;
          borrow_q    <= s_c_out;
          gnt_q       <= 2'b00;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (hs) begin
            rsp_valid_q <= 2'b00;
            if (|req) begin
              a_q     <= a_d;
              b_q     <= b_d;
              cin_q   <= cin_d;
              gnt_q   <= win_d ? 2'b10 : 2'b01;
              owner_q <= win_d;
              last_q  <= win_d;
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
  assign a_sub      = a_q;
  assign b_sub      = b_q;
  assign s_c_in     = cin_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: directed checks of sub_arbiter
// with a behavioural subtractor on its datapath port.
module tb_sub_arbiter;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             bin0, bin1;
  logic [1:0]       gnt;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic [WIDTH-1:0] a_sub, b_sub;
  logic             s_c_in;
  logic [WIDTH-1:0] difference;
  logic             s_c_out;
  logic [WIDTH:0]   full;

  int pass_cnt;
  int total_cnt;

  sub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .a0(a0),
    .b0(b0),
    .bin0(bin0),
    .a1(a1),
    .b1(b1),
    .bin1(bin1),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .diff_out(diff_out),
    .borrow_out(borrow_out),
    .a_sub(a_sub),
    .b_sub(b_sub),
    .s_c_in(s_c_in),
    .difference(difference),
    .s_c_out(s_c_out)
  );

  assign full = {1'b0, a_sub} - {1'b0, b_sub}
              - {{WIDTH{1'b0}}, s_c_in};
  assign difference = full[WIDTH-1:0];
  assign s_c_out    = full[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b11;
    rsp_ready = 2'b00;
    a0 = 64'd63; b0 = 64'd21; bin0 = 1'b0;
    a1 = 64'd5;  b1 = 64'd2;  bin1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (gnt !== 2'b00 || rsp_valid !== 2'b00 ||
          diff_out !== '0 || a_sub !== '0)
        $display("FAIL reset_hold%0d gnt=%b rv=%b diff=%h a=%h want 0",
                 i, gnt, rsp_valid, diff_out, a_sub);
      else pass_cnt++;
    end
    reset = 1'b0;
    tick();
    total_cnt++;
    if (gnt !== 2'b01 || a_sub !== 64'd63)
      $display("FAIL reset_first_gnt gnt=%b a_sub=%0d want 01/63",
               gnt, a_sub);
    else pass_cnt++;
    req = 2'b00;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || diff_out !== 64'd42)
      $display("FAIL reset_first_rsp rv=%b diff=%0d want 01/42",
               rsp_valid, diff_out);
    else pass_cnt++;
    rsp_ready = 2'b11;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL reset_first_hs rv=%b want 00", rsp_valid);
    else pass_cnt++;
    rsp_ready = 2'b00;
  endtask

  task automatic test_req0_alone();
    a0 = 64'd63; b0 = 64'd21; bin0 = 1'b0;
    req = 2'b01;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b01 || rsp_valid !== 2'b00)
      $display("FAIL r0_gnt gnt=%b rv=%b want 01/00", gnt, rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || gnt !== 2'b00 ||
        diff_out !== 64'd42 || borrow_out !== 1'b0)
      $display("FAIL r0_rsp rv=%b gnt=%b diff=%0d bo=%b want 01/00/42/0",
               rsp_valid, gnt, diff_out, borrow_out);
    else pass_cnt++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL r0_hs rv=%b want 00", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_req1_neg();
    a1 = 64'd30; b1 = 64'd90; bin1 = 1'b0;
    req = 2'b10;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b10)
      $display("FAIL r1n_gnt gnt=%b want 10", gnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10 || diff_out !== 64'hFFFFFFFFFFFFFFC4 ||
        borrow_out !== 1'b1)
      $display("FAIL r1n_rsp rv=%b diff=%h bo=%b want 10/ffffffffffffffc4/1",
               rsp_valid, diff_out, borrow_out);
    else pass_cnt++;
    rsp_ready = 2'b01;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10)
      $display("FAIL r1n_nonowner_ready rv=%b want 10", rsp_valid);
    else pass_cnt++;
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL r1n_hs rv=%b want 00", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_req1_borrow_in();
    a1 = 64'd0; b1 = 64'd0; bin1 = 1'b1;
    req = 2'b10;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b10 || s_c_in !== 1'b1)
      $display("FAIL r1b_gnt gnt=%b cin=%b want 10/1", gnt, s_c_in);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10 || diff_out !== 64'hFFFFFFFFFFFFFFFF ||
        borrow_out !== 1'b1)
      $display("FAIL r1b_rsp rv=%b diff=%h bo=%b want 10/ffffffffffffffff/1",
               rsp_valid, diff_out, borrow_out);
    else pass_cnt++;
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    bin1 = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0]       g_exp;
    logic [WIDTH-1:0] d_exp;
    a0 = 64'd13123124; b0 = 64'd999922; bin0 = 1'b0;
    a1 = 64'd63;       b1 = 64'd21;     bin1 = 1'b0;
    req = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      d_exp = (i % 2 == 0) ? 64'd12123202 : 64'd42;
      tick();
      total_cnt++;
      if (gnt !== g_exp || rsp_valid !== 2'b00)
        $display("FAIL cont_gnt%0d gnt=%b rv=%b want %b/00",
                 i, gnt, rsp_valid, g_exp);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (gnt !== 2'b00 || rsp_valid !== g_exp || diff_out !== d_exp)
        $display("FAIL cont_rsp%0d gnt=%b rv=%b diff=%0d want 00/%b/%0d",
                 i, gnt, rsp_valid, diff_out, g_exp, d_exp);
      else pass_cnt++;
    end
    req = 2'b00;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b00 || gnt !== 2'b00)
      $display("FAIL cont_drain gnt=%b rv=%b want 00/00", gnt, rsp_valid);
    else pass_cnt++;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    a0 = 64'd100; b0 = 64'd1; bin0 = 1'b0;
    a1 = 64'd7;   b1 = 64'd3; bin1 = 1'b0;
    rsp_ready = 2'b00;
    req = 2'b01;
    tick();
    req = 2'b10;
    total_cnt++;
    if (gnt !== 2'b01)
      $display("FAIL bp_gnt0 gnt=%b want 01", gnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || diff_out !== 64'd99)
      $display("FAIL bp_rsp0 rv=%b diff=%0d want 01/99", rsp_valid, diff_out);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (rsp_valid !== 2'b01 || gnt !== 2'b00 || diff_out !== 64'd99 ||
          a_sub !== 64'd100)
        $display("FAIL bp_hold%0d rv=%b gnt=%b diff=%0d a=%0d want 01/00/99/100",
                 i, rsp_valid, gnt, diff_out, a_sub);
      else pass_cnt++;
    end
    rsp_ready = 2'b01;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b10 || rsp_valid !== 2'b00)
      $display("FAIL bp_gnt1 gnt=%b rv=%b want 10/00", gnt, rsp_valid);
    else pass_cnt++;
    rsp_ready = 2'b11;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10 || diff_out !== 64'd4)
      $display("FAIL bp_rsp1 rv=%b diff=%0d want 10/4", rsp_valid, diff_out);
    else pass_cnt++;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    a0 = 64'd63; b0 = 64'd21; bin0 = 1'b0;
    rsp_ready = 2'b11;
    req = 2'b01;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b01)
      $display("FAIL rm_gnt gnt=%b want 01", gnt);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (gnt !== 2'b00 || rsp_valid !== 2'b00 || diff_out !== '0 ||
        borrow_out !== 1'b0 || a_sub !== '0 || b_sub !== '0 ||
        s_c_in !== 1'b0)
      $display("FAIL rm_zero gnt=%b rv=%b diff=%h bo=%b a=%h b=%h cin=%b want 0",
               gnt, rsp_valid, diff_out, borrow_out, a_sub, b_sub, s_c_in);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (rsp_valid !== 2'b00)
        $display("FAIL rm_norsp%0d rv=%b want 00", i, rsp_valid);
      else pass_cnt++;
    end
    a1 = 64'd9; b1 = 64'd4;
    req = 2'b11;
    tick();
    req = 2'b00;
    total_cnt++;
    if (gnt !== 2'b01)
      $display("FAIL rm_ptr gnt=%b want 01", gnt);
    else pass_cnt++;
    tick();
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    req = 2'b00;
    rsp_ready = 2'b00;
    a0 = '0; b0 = '0; bin0 = 1'b0;
    a1 = '0; b1 = '0; bin1 = 1'b0;
    test_reset();
    test_req0_alone();
    test_req1_neg();
    test_req1_borrow_in();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
